// File: rtl/alu_sequencer.sv
// alu_sequencer: issue and writeback stage wrapped around a combinational ALU.
// Takes one 32-bit instruction at a time over valid/ready. Operands are read
// from an internal register file and presented to the ALU from registers.
// The ALU answer is then written back to the destination register.
// A sticky error status and a debug read port are also provided.
module alu_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 8,
    parameter int ADDR_W     = $clog2(REG_COUNT)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr_word,
    output logic [3:0]            alu_operation,
    output logic [DATA_WIDTH-1:0] alu_operand_a,
    output logic [DATA_WIDTH-1:0] alu_operand_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [1:0]            alu_error_flag,
    output logic                  done,
    output logic [1:0]            done_error,
    output logic [1:0]            status_error,
    input  logic                  clear_status,
    input  logic [ADDR_W-1:0]     read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXECUTE,
        S_WRITEBACK
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
    logic [ADDR_W-1:0]     r_rd;
    logic                  r_illegal;
    logic [3:0]            r_op;
    logic [DATA_WIDTH-1:0] r_opa;
    logic [DATA_WIDTH-1:0] r_opb;
    logic                  r_done;
    logic [1:0]            r_done_err;
    logic [1:0]            r_status;

    logic [3:0]            w_opcode;
    logic [ADDR_W-1:0]     w_rd;
    logic [ADDR_W-1:0]     w_rs_a;
    logic [ADDR_W-1:0]     w_rs_b;
    logic                  w_imm_sel;
    logic [15:0]           w_imm;
    logic                  w_legal;
    logic [DATA_WIDTH-1:0] w_opa;
    logic [DATA_WIDTH-1:0] w_opb;
    logic [1:0]            w_eff_err;
    logic                  w_unused;

    // Instruction field split; bits [17:16] carry nothing.
    assign w_opcode  = instr_word[31:28];
    assign w_rd      = instr_word[27:25];
    assign w_rs_a    = instr_word[24:22];
    assign w_rs_b    = instr_word[21:19];
    assign w_imm_sel = instr_word[18];
    assign w_imm     = instr_word[15:0];
    assign w_unused  = &{1'b0, instr_word[17:16]};

    // Opcode legality; anything outside the supported set is flagged as illegal.
    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            4'b0010, 4'b0011, 4'b0100, 4'b0110,
            4'b0111, 4'b1000, 4'b1001: w_legal = 1'b1;
            default:                   w_legal = 1'b0;
        endcase
    end

    // Operand fetch: register r0 always reads as zero; the immediate is zero-extended.
    assign w_opa = (w_rs_a == '0) ? '0 : r_regs[w_rs_a];
    assign w_opb = w_imm_sel ? {{(DATA_WIDTH-16){1'b0}}, w_imm}
                             : ((w_rs_b == '0) ? '0 : r_regs[w_rs_b]);

    // An illegal opcode overrides whatever the ALU reports.
    assign w_eff_err = r_illegal ? 2'b11 : alu_error_flag;

    assign instr_ready   = (r_state == S_IDLE);
    assign alu_operation = r_op;
    assign alu_operand_a = r_opa;
    assign alu_operand_b = r_opb;
    assign done          = r_done;
    assign done_error    = r_done_err;
    assign status_error  = r_status;
    assign read_data     = (read_addr == '0) ? '0 : r_regs[read_addr];

    // Issue/execute/writeback sequencing, operand registers and register-file writeback.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_rd       <= '0;
            r_illegal  <= 1'b0;
            r_op       <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_done     <= 1'b0;
            r_done_err <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_op      <= w_opcode;
                        r_opa     <= w_opa;
                        r_opb     <= w_opb;
                        r_rd      <= w_rd;
                        r_illegal <= !w_legal;
                        r_state   <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (w_eff_err == 2'b00 && r_rd != '0) begin
                        r_regs[r_rd] <= alu_result;
                    end
                    r_done     <= 1'b1;
                    r_done_err <= w_eff_err;
                    r_state    <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky status: the first error wins. A clear that coincides with a new error yields the new error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_status <= '0;
        end else if (r_state == S_EXECUTE && w_eff_err != 2'b00 &&
                     (r_status == 2'b00 || clear_status)) begin
            r_status <= w_eff_err;
        end else if (clear_status) begin
            r_status <= '0;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a behavioural ALU attached.
module tb_alu_sequencer;

    localparam int DW = 32;

    logic        clock;
    logic        reset_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic [3:0]  alu_operation;
    logic [DW-1:0] alu_operand_a;
    logic [DW-1:0] alu_operand_b;
    logic [DW-1:0] alu_result;
    logic [1:0]  alu_error_flag;
    logic        done;
    logic [1:0]  done_error;
    logic [1:0]  status_error;
    logic        clear_status;
    logic [2:0]  read_addr;
    logic [DW-1:0] read_data;

    typedef struct {
        logic [2:0]  rd;
        logic [1:0]  err;
        logic [31:0] val;
        int          acc;
    } sbEntry_t;

    sbEntry_t    sb[$];
    logic [31:0] model [8];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          expOpbCycle = -1;
    logic [3:0]  expOp;
    logic [31:0] expOpa;
    logic [31:0] expOpb;
    bit          chainMode = 0;
    bit          chainSeen = 0;
    int          lastAcc = 0;

    alu_sequencer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_word    (instr_word),
        .alu_operation (alu_operation),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_result    (alu_result),
        .alu_error_flag(alu_error_flag),
        .done          (done),
        .done_error    (done_error),
        .status_error  (status_error),
        .clear_status  (clear_status),
        .read_addr     (read_addr),
        .read_data     (read_data)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural ALU: {error, result}; unknown opcodes return no error so the sequencer must flag them.
    function automatic logic [33:0] aluCalc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0010: aluCalc = {2'b00, a * b};
            4'b0011: aluCalc = {2'b00, a + b};
            4'b0100: aluCalc = {2'b00, a - b};
            4'b0110: aluCalc = (b == 0) ? {2'b01, 32'h0} : {2'b00, a / b};
            4'b0111: aluCalc = {2'b00, a & b};
            4'b1000: aluCalc = {2'b00, a | b};
            4'b1001: aluCalc = {2'b00, (a < b) ? 32'd1 : 32'd0};
            default: aluCalc = {2'b00, 32'h0};
        endcase
    endfunction

    function automatic bit isLegal(input logic [3:0] op);
        return op inside {4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111, 4'b1000, 4'b1001};
    endfunction

    // The ALU the sequencer drives.
    always_comb begin
        {alu_error_flag, alu_result} = aluCalc(alu_operation, alu_operand_a, alu_operand_b);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Accept monitor: predicts each accepted instruction and pushes the expectation.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) model[i] = '0;
            sb.delete();
            chainSeen = 0;
        end else begin
            if (instr_valid && instr_ready) begin
                logic [3:0]  op;
                logic [2:0]  rd, ra, rb;
                logic [31:0] a, b;
                logic [33:0] r;
                sbEntry_t    e;
                op = instr_word[31:28];
                rd = instr_word[27:25];
                ra = instr_word[24:22];
                rb = instr_word[21:19];
                a  = (ra == 0) ? 32'h0 : model[ra];
                b  = instr_word[18] ? {16'h0, instr_word[15:0]} : ((rb == 0) ? 32'h0 : model[rb]);
                r  = aluCalc(op, a, b);
                e.err = isLegal(op) ? r[33:32] : 2'b11;
                if (e.err == 2'b00 && rd != 0) model[rd] = r[31:0];
                e.rd  = rd;
                e.val = (rd == 0) ? 32'h0 : model[rd];
                e.acc = cyc;
                sb.push_back(e);
                expOp  = op;
                expOpa = a;
                expOpb = b;
                expOpbCycle = cyc + 1;
                if (chainMode) begin
                    if (chainSeen) checkOutput("accept_spacing", cyc - lastAcc, 3);
                    chainSeen = 1;
                end else begin
                    chainSeen = 0;
                end
                lastAcc = cyc;
            end
            cyc = cyc + 1;
        end
    end

    // Output checker: operand registers in EXECUTE, completion and writeback on done.
    always @(negedge clock) begin
        if (reset_n) begin
            if (cyc == expOpbCycle) begin
                checkOutput("alu_operation", {28'h0, alu_operation}, {28'h0, expOp});
                checkOutput("alu_operand_a", alu_operand_a, expOpa);
                checkOutput("alu_operand_b", alu_operand_b, expOpb);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    sbEntry_t e;
                    e = sb.pop_front();
                    checkOutput("done_error", {30'h0, done_error}, {30'h0, e.err});
                    checkOutput("done_latency", cyc - e.acc, 2);
                    read_addr = e.rd;
                    #1;
                    checkOutput($sformatf("reg_r%0d", e.rd), read_data, e.val);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                                 input logic [2:0] rb, input logic immSel, input logic [15:0] imm,
                                 input bit keep);
        int n = 0;
        @(negedge clock);
        instr_word  = {op, rd, ra, rb, immSel, 2'b00, imm};
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!instr_ready) begin
            checkOutput("ready_timeout", 0, 1);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clock);
        while ((sb.size() != 0 || !instr_ready) && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0 || !instr_ready) checkOutput("drain_timeout", 0, 1);
    endtask

    task automatic pulseClear();
        @(negedge clock);
        clear_status = 1'b1;
        @(posedge clock);
        #1;
        clear_status = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        reset_n      = 1'b0;
        instr_valid  = 1'b0;
        instr_word   = '0;
        clear_status = 1'b0;
        read_addr    = '0;
        repeat (3) @(negedge clock);
        checkOutput("rst_operation", {28'h0, alu_operation}, 0);
        checkOutput("rst_operand_a", alu_operand_a, 0);
        checkOutput("rst_operand_b", alu_operand_b, 0);
        checkOutput("rst_done", {31'h0, done}, 0);
        checkOutput("rst_done_error", {30'h0, done_error}, 0);
        checkOutput("rst_status", {30'h0, status_error}, 0);
        #2 reset_n = 1'b1;
        @(negedge clock);
        checkOutput("rst_ready", {31'h0, instr_ready}, 1);

        $display("[TB] immediate load");
        applyStimulus(4'b0011, 3'd1, 3'd0, 3'd0, 1'b1, 16'd10, 0);
        waitIdle();
        checkOutput("status_after_add", {30'h0, status_error}, 2'b00);

        $display("[TB] register chain with valid held");
        chainMode = 1;
        applyStimulus(4'b0011, 3'd2, 3'd0, 3'd0, 1'b1, 16'd5, 1);
        applyStimulus(4'b0100, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, 1);
        applyStimulus(4'b0010, 3'd4, 3'd3, 3'd2, 1'b0, 16'd0, 0);
        waitIdle();
        chainMode = 0;

        $display("[TB] divide by zero");
        applyStimulus(4'b0011, 3'd5, 3'd0, 3'd0, 1'b1, 16'd40, 0);
        applyStimulus(4'b0110, 3'd5, 3'd1, 3'd0, 1'b0, 16'd0, 0);
        waitIdle();
        checkOutput("status_div0", {30'h0, status_error}, 2'b01);
        applyStimulus(4'b0011, 3'd7, 3'd1, 3'd0, 1'b1, 16'd1, 0);
        waitIdle();
        checkOutput("status_sticky", {30'h0, status_error}, 2'b01);

        $display("[TB] illegal opcode");
        applyStimulus(4'b0011, 3'd6, 3'd0, 3'd0, 1'b1, 16'd7, 0);
        applyStimulus(4'b1111, 3'd6, 3'd1, 3'd2, 1'b0, 16'd0, 0);
        waitIdle();
        checkOutput("status_first_wins", {30'h0, status_error}, 2'b01);
        pulseClear();
        @(negedge clock);
        checkOutput("status_cleared", {30'h0, status_error}, 2'b00);

        $display("[TB] clear coinciding with a new error");
        applyStimulus(4'b0110, 3'd7, 3'd2, 3'd0, 1'b0, 16'd0, 0);
        waitIdle();
        checkOutput("status_div0_again", {30'h0, status_error}, 2'b01);
        applyStimulus(4'b1110, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, 0);
        clear_status = 1'b1;
        @(posedge clock);
        #1;
        clear_status = 1'b0;
        waitIdle();
        checkOutput("status_clear_vs_error", {30'h0, status_error}, 2'b11);

        $display("[TB] r0 protection");
        applyStimulus(4'b0011, 3'd0, 3'd0, 3'd0, 1'b1, 16'd99, 0);
        applyStimulus(4'b0011, 3'd1, 3'd0, 3'd0, 1'b0, 16'd0, 0);
        waitIdle();

        $display("[TB] reset during execute");
        applyStimulus(4'b0011, 3'd2, 3'd3, 3'd0, 1'b1, 16'd3, 0);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrst_operation", {28'h0, alu_operation}, 0);
        checkOutput("midrst_operand_a", alu_operand_a, 0);
        checkOutput("midrst_operand_b", alu_operand_b, 0);
        checkOutput("midrst_done", {31'h0, done}, 0);
        checkOutput("midrst_status", {30'h0, status_error}, 0);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("midrst_no_done", {31'h0, done}, 0);
        end
        checkOutput("midrst_ready", {31'h0, instr_ready}, 1);
        applyStimulus(4'b0011, 3'd3, 3'd2, 3'd0, 1'b1, 16'd5, 0);
        waitIdle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue and writeback stage wrapped around the combinational ALU.
- Accepts 32-bit instruction words over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU operation/operand inputs from registers, then captures result and error_flag and writes the result back.
- Maintains a sticky error status and exposes a debug read port for the register file.

Parameters:
DATA_WIDTH, 32, operand/result/register width
REG_COUNT, 8, number of registers; address width ADDR_W = log2(REG_COUNT) = 3

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
instr_valid  input  1  instruction word present
instr_ready  output  1  sequencer can accept an instruction
instr_word  input  32  [31:28] opcode, [27:25] rd, [24:22] rs_a, [21:19] rs_b, [18] imm_sel, [15:0] imm
alu_operation  output  4  to ALU operation
alu_operand_a  output  DATA_WIDTH  to ALU operand_a
alu_operand_b  output  DATA_WIDTH  to ALU operand_b
alu_result  input  DATA_WIDTH  from ALU result (combinational)
alu_error_flag  input  2  from ALU error_flag; 2'b00 = no error
done  output  1  one-cycle pulse per completed instruction
done_error  output  2  error code of the completed instruction, valid while done=1
status_error  output  2  sticky: first nonzero error code since reset/clear
clear_status  input  1  synchronous clear of status_error
read_addr  input  ADDR_W  debug register select
read_data  output  DATA_WIDTH  combinational register contents; r0 reads 0

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All registers go to 0 and the FSM goes to IDLE.
  - alu_operation=0, alu_operand_a=0, alu_operand_b=0.
  - done=0, done_error=0, status_error=0.
  - instr_ready=1 after reset is released.
- Reset asserted mid-instruction aborts it: no writeback and no done pulse.
- Legal opcodes: 0010 MUL, 0011 ADD, 0100 SUB, 0110 DIV, 0111 AND, 1000 OR, 1001 CMP. All other opcodes are illegal.
- FSM states are IDLE, EXECUTE and WRITEBACK.
- IDLE:
  - instr_ready=1.
  - On a rising edge with instr_valid=1, the instruction is accepted.
  - alu_operation is loaded with the opcode.
  - alu_operand_a is loaded with R[rs_a].
  - alu_operand_b is loaded with R[rs_b] if imm_sel=0, else the zero-extended imm.
  - rd and an illegal-opcode marker are latched, and the FSM moves to EXECUTE.
- EXECUTE:
  - instr_ready=0; the ALU outputs are held stable for the whole cycle.
  - At the next edge, alu_result and alu_error_flag are sampled.
  - The effective error is 2'b11 if the opcode is illegal, else alu_error_flag.
  - If the effective error is 00 and rd≠0, R[rd] <= alu_result.
  - done <= 1, done_error <= effective error, and the FSM moves to WRITEBACK.
- WRITEBACK:
  - done=1 for exactly this cycle; instr_ready=0.
  - At the next edge done <= 0 and the FSM returns to IDLE.
- Throughput and latency:
  - One instruction every 3 cycles.
  - Latency from the accept edge to the done-high edge is 2 cycles.
- Errors:
  - A nonzero effective error suppresses writeback; the destination register keeps its old value.
  - status_error latches the error code only while it is 00, so the first error wins.
  - clear_status=1 clears it at the edge. If clear_status coincides with a new error, the new error is latched.
- r0:
  - Writes to r0 are ignored.
  - Reads of r0, including operand fetch, return 0.
- Read-after-write: an instruction accepted in the IDLE cycle that follows WRITEBACK sees the updated register. No bypass is needed because there is no overlap.
- instr_valid while instr_ready=0 is ignored. The word is not buffered; the producer must hold it until it is accepted.
- Registered ALU outputs hold their last values in IDLE.
- Arithmetic width and wrap-around are owned by the ALU; the sequencer writes all DATA_WIDTH bits of the result unchanged.

Test Plan:
- Reset then immediate-load path:
  - Stimulus: ADD r1=r0+imm 10 (opcode 0011, imm_sel=1), with the bench ALU model returning operand_a+operand_b.
  - Required: alu_operand_b=10 one cycle after accept; done pulses 2 cycles after accept; read_addr=1 gives read_data=10; status_error=00.
- Register-register chain:
  - Stimulus: r1=10, r2=5; then SUB r3=r1-r2, MUL r4=r3*r2, issued back-to-back with instr_valid held high.
  - Required: r3=5, r4=25; instr_ready low for 2 cycles per instruction; accepts are 3 cycles apart.
- Divide by zero:
  - Stimulus: r5=40 preloaded; DIV r5=r1/r0 with the ALU returning error 01.
  - Required: done_error=01; r5 still 40; status_error=01. A following good ADD leaves status_error=01.
- Illegal opcode:
  - Stimulus: opcode 1111 targeting r6 (previously 7).
  - Required: done_error=11; r6=7.
  - Then clear_status=1 for one cycle: status_error=00.
- r0 protection:
  - Stimulus: ADD r0=r0+imm 99.
  - Required: done=1, done_error=00; read_addr=0 gives 0; a subsequent ADD r1=r0+r0 writes 0.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 during EXECUTE of ADD r2=... .
  - Required: alu_* outputs, done and status_error go to 0 immediately; r2=0; no done pulse after reset releases; instr_ready=1.
